// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for cpu_mem_arbiter: FSM states, grant encoding, latched request
// and the fetch-vs-data grant rule.
package arb_types;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INST = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_INST = 1'b0,
      GRANT_DATA = 1'b1
   } arb_grant_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mbe;
      logic        we;
   } arb_req_t;

   localparam logic [3:0] MBE_FULL = 4'b1111;

   // Data wins, except right after a data grant while a fetch is waiting.
   function automatic arb_grant_t pick_grant(input logic       inst_pend,
                                             input logic       data_pend,
                                             input arb_grant_t last);
      if (data_pend && !(inst_pend && (last == GRANT_DATA))) begin
         return GRANT_DATA;
      end
      return GRANT_INST;
   endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between the CPU, the arbiter and the downstream memory port.
// Handshake: a requester raises read/write (with addr/wdata/mbe stable) and holds
// it until the responder pulses resp for exactly one cycle; rdata is valid only
// in that resp cycle. The arbiter answers the CPU side and requests the memory side.
interface cpu_mem_arbiter_if;

   logic        inst_read;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_resp;

   logic        data_read;
   logic        data_write;
   logic [3:0]  data_mbe;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_resp;

   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_mbe;
   logic [31:0] mem_rdata;
   logic        mem_resp;

   // Arbiter view.
   modport slave (
      input  inst_read, inst_addr,
      output inst_rdata, inst_resp,
      input  data_read, data_write, data_mbe, data_addr, data_wdata,
      output data_rdata, data_resp,
      output mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
      input  mem_rdata, mem_resp
   );

   // CPU plus memory view.
   modport master (
      output inst_read, inst_addr,
      input  inst_rdata, inst_resp,
      output data_read, data_write, data_mbe, data_addr, data_wdata,
      input  data_rdata, data_resp,
      input  mem_read, mem_write, mem_addr, mem_wdata, mem_mbe,
      output mem_rdata, mem_resp
   );

endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: serializes CPU fetch and load/store requests onto one memory port.
// Define ARB_RESP_REG_EN to register the CPU responses through an extra RESP state.
module cpu_mem_arbiter
   import arb_types::*;
(
   input  logic             clk,
   input  logic             rst,
   cpu_mem_arbiter_if.slave bus,
   output arb_state_t       dbg_state
);

`ifdef ARB_RESP_REG_EN
   localparam arb_state_t DONE_STATE = RESP;
`else
   localparam arb_state_t DONE_STATE = IDLE;
`endif

   arb_state_t state;
   arb_state_t state_next;
   arb_grant_t last_grant;
   arb_grant_t last_grant_next;
   arb_grant_t grant;
   arb_req_t   req;
   arb_req_t   req_next;

   logic inst_pend;
   logic data_pend;
   logic inst_hit;
   logic data_hit;

   assign inst_pend = bus.inst_read;
   assign data_pend = bus.data_read | bus.data_write;
   assign grant     = pick_grant(inst_pend, data_pend, last_grant);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= GRANT_INST;
         req        <= '0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         req        <= req_next;
      end
   end

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      req_next        = req;
      case (state)
         IDLE: begin
            if (inst_pend || data_pend) begin
               last_grant_next = grant;
               if (grant == GRANT_DATA) begin
                  state_next     = DATA;
                  req_next.addr  = bus.data_addr;
                  req_next.wdata = bus.data_wdata;
                  req_next.mbe   = bus.data_mbe;
                  // read+write together is resolved as a store
                  req_next.we    = bus.data_write;
               end else begin
                  state_next     = INST;
                  req_next.addr  = bus.inst_addr;
                  req_next.wdata = '0;
                  req_next.mbe   = MBE_FULL;
                  req_next.we    = 1'b0;
               end
            end
         end
         INST, DATA: begin
            if (bus.mem_resp) begin
               state_next = DONE_STATE;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Downstream side comes only from the latched request and the state register.
   assign bus.mem_read  = (state == INST) || ((state == DATA) && !req.we);
   assign bus.mem_write = (state == DATA) && req.we;
   assign bus.mem_addr  = req.addr;
   assign bus.mem_wdata = req.wdata;
   assign bus.mem_mbe   = req.mbe;

   assign inst_hit = (state == INST) && bus.mem_resp;
   assign data_hit = (state == DATA) && bus.mem_resp;

`ifdef ARB_RESP_REG_EN
   logic        inst_resp_q;
   logic        data_resp_q;
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_resp_q <= 1'b0;
         data_resp_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         inst_resp_q <= inst_hit;
         data_resp_q <= data_hit;
         rdata_q     <= (inst_hit || data_hit) ? bus.mem_rdata : '0;
      end
   end

   assign bus.inst_resp  = inst_resp_q;
   assign bus.data_resp  = data_resp_q;
   assign bus.inst_rdata = inst_resp_q ? rdata_q : '0;
   assign bus.data_rdata = data_resp_q ? rdata_q : '0;
`else
   assign bus.inst_resp  = inst_hit;
   assign bus.data_resp  = data_hit;
   assign bus.inst_rdata = inst_hit ? bus.mem_rdata : '0;
   assign bus.data_rdata = data_hit ? bus.mem_rdata : '0;
`endif

   assign dbg_state = state;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios then randomized
// traffic against a cycle-level model of the grant/response rules.
`timescale 1ns/1ps
module tb_cpu_mem_arbiter;
   import arb_types::*;

`ifdef ARB_RESP_REG_EN
   localparam int RESP_DLY = 1;
`else
   localparam int RESP_DLY = 0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   always #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   cpu_mem_arbiter_if bus();
   arb_state_t dbg_state;

   cpu_mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_inst_q[$];
   logic [31:0] exp_data_q[$];
   logic [31:0] mem_store[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];
   int mem_act_cnt = 0;

   int mem_lat    = 0;
   bit lat_rand   = 1'b0;
   bit force_resp = 1'b0;
   int wait_cnt   = 0;
   int cur_lat    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      if (a == 32'h60) return 32'h0000_0013;
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] mbe);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (mbe[b]) r[8*b +: 8] = new_w[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   // ---------------- downstream memory ----------------
   initial begin
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_resp  = 1'b0;
         bus.mem_rdata = '0;
         if (force_resp) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = 32'hBAD0_BAD0;
         end else if (bus.mem_read || bus.mem_write) begin
            if (wait_cnt == 0) cur_lat = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
            if (wait_cnt >= cur_lat) begin
               bus.mem_resp = 1'b1;
               if (bus.mem_write) mem_store[bus.mem_addr] = merge(mem_word(bus.mem_addr), bus.mem_wdata, bus.mem_mbe);
               else bus.mem_rdata = mem_word(bus.mem_addr);
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // ---------------- reference model + monitor ----------------
   bit          m_busy = 0, m_start = 0, m_resp_cyc = 0;
   arb_grant_t  m_g = GRANT_INST, m_last = GRANT_INST;
   logic [31:0] m_addr = '0, m_wdata = '0;
   logic [3:0]  m_mbe = '0;
   logic        m_we = 1'b0;
   logic        d_i = 1'b0, d_d = 1'b0, e_i, e_d;

   initial forever begin
      @(negedge clk);
      if (rst) begin
         m_busy = 0; m_start = 0; m_resp_cyc = 0; m_last = GRANT_INST; d_i = 0; d_d = 0;
         continue;
      end
      e_i = 1'b0;
      e_d = 1'b0;
`ifdef ARB_RESP_REG_EN
      e_i = d_i;
      e_d = d_d;
`else
      if (m_busy && bus.mem_resp) begin
         e_i = (m_g == GRANT_INST);
         e_d = (m_g == GRANT_DATA);
      end
`endif
      check("inst_resp", 32'(bus.inst_resp), 32'(e_i));
      check("data_resp", 32'(bus.data_resp), 32'(e_d));
      check("resp_exclusive", 32'(bus.inst_resp & bus.data_resp), 32'h0);
      if (bus.inst_resp) begin
         if (exp_inst_q.size() == 0) check("inst_resp_unexpected", 32'h1, 32'h0);
         else check("inst_rdata", bus.inst_rdata, exp_inst_q.pop_front());
      end else check("inst_rdata_idle", bus.inst_rdata, 32'h0);
      if (bus.data_resp) begin
         if (exp_data_q.size() == 0) check("data_resp_unexpected", 32'h1, 32'h0);
         else check("data_rdata", bus.data_rdata, exp_data_q.pop_front());
      end else check("data_rdata_idle", bus.data_rdata, 32'h0);
      if (bus.mem_read || bus.mem_write) mem_act_cnt++;

      if (m_busy) begin
         check("mem_read", 32'(bus.mem_read), 32'(m_g == GRANT_INST || !m_we));
         check("mem_write", 32'(bus.mem_write), 32'(m_g == GRANT_DATA && m_we));
         check("mem_addr", bus.mem_addr, m_addr);
         check("mem_wdata", bus.mem_wdata, (m_g == GRANT_INST) ? 32'h0 : m_wdata);
         check("mem_mbe", 32'(bus.mem_mbe), (m_g == GRANT_INST) ? 32'hF : 32'(m_mbe));
         if (m_start) check("grant", 32'(dbg_state), (m_g == GRANT_INST) ? 32'(INST) : 32'(DATA));
         m_start = 0;
      end else begin
         check("mem_idle", 32'({bus.mem_read, bus.mem_write}), 32'h0);
      end

      d_i = 1'b0;
      d_d = 1'b0;
      if (m_busy) begin
         if (bus.mem_resp) begin
            m_busy = 0;
`ifdef ARB_RESP_REG_EN
            d_i = (m_g == GRANT_INST);
            d_d = (m_g == GRANT_DATA);
            m_resp_cyc = 1;
`endif
         end
      end else if (m_resp_cyc) begin
         m_resp_cyc = 0;
      end else if (bus.inst_read || bus.data_read || bus.data_write) begin
         // data first, but a waiting fetch goes next after any data grant
         if ((bus.data_read || bus.data_write) && !(bus.inst_read && m_last == GRANT_DATA)) begin
            m_g = GRANT_DATA; m_addr = bus.data_addr; m_wdata = bus.data_wdata;
            m_mbe = bus.data_mbe; m_we = bus.data_write;
         end else begin
            m_g = GRANT_INST; m_addr = bus.inst_addr; m_wdata = '0; m_mbe = 4'hF; m_we = 1'b0;
         end
         m_last  = m_g;
         m_busy  = 1;
         m_start = 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_resp(input logic is_inst, input int drop_after, output int resp_cyc);
      int n;
      n = 0;
      resp_cyc = -1;
      forever begin
         @(negedge clk);
         n++;
         if (is_inst ? bus.inst_resp : bus.data_resp) begin
            resp_cyc = cyc;
            break;
         end
         if (n >= 200) break;
         @(posedge clk);
         #1;
         if (is_inst && n == drop_after) bus.inst_read = 1'b0;
      end
      if (resp_cyc < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: no resp within %0d cycles, required one", is_inst ? "inst" : "data", n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_inst(input logic [31:0] a, input int drop_after, output int ic, output int rc);
      bus.inst_read = 1'b1;
      bus.inst_addr = a;
      exp_inst_q.push_back(init_word(a));
      ic = cyc;
      wait_resp(1'b1, drop_after, rc);
      bus.inst_read = 1'b0;
   endtask

   task automatic do_data(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] mbe, output int ic, output int rc);
      bus.data_read  = rd;
      bus.data_write = wr;
      bus.data_addr  = a;
      bus.data_wdata = wd;
      bus.data_mbe   = mbe;
      if (wr) begin
         ref_mem[a] = merge(ref_read(a), wd, mbe);
         exp_data_q.push_back(32'h0);
      end else begin
         exp_data_q.push_back(ref_read(a));
      end
      ic = cyc;
      wait_resp(1'b0, -1, rc);
      bus.data_read  = 1'b0;
      bus.data_write = 1'b0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, 32'({bus.mem_read, bus.mem_write, bus.inst_resp, bus.data_resp}), 32'h0);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
      check({tag, "_mem_mbe"}, 32'(bus.mem_mbe), 32'h0);
      check({tag, "_rdata"}, bus.inst_rdata | bus.data_rdata, 32'h0);
      check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int ic, rc, dc, drc, dc2, drc2, act0;
      bus.inst_read = 1'b0; bus.inst_addr = '0;
      bus.data_read = 1'b0; bus.data_write = 1'b0; bus.data_addr = '0;
      bus.data_wdata = '0;  bus.data_mbe = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      // single fetch, 1-cycle memory
      do_inst(32'h60, -1, ic, rc);
      check("s1_latency", 32'(rc - ic), 32'(1 + RESP_DLY));

      // simultaneous fetch and load: load first
      fork
         do_inst(32'h64, -1, ic, rc);
         do_data(1'b1, 1'b0, 32'h100, $urandom, 4'hF, dc, drc);
      join
      check("s2_data_first", 32'(drc < rc), 32'h1);

      // store then another data request while a fetch waits: fetch goes second
      fork
         begin
            do_data(1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011, dc, drc);
            do_data(1'b1, 1'b0, 32'h204, 32'h0, 4'hF, dc2, drc2);
         end
         begin
            @(posedge clk);
            #1;
            do_inst(32'h68, -1, ic, rc);
         end
      join
      check("s3_inst_before_data2", 32'(rc < drc2), 32'h1);
      check("s3_store_bytes", mem_word(32'h200), merge(init_word(32'h200), 32'hDEADBEEF, 4'b0011));

      // 5-cycle memory, fetch dropped in cycle 2
      mem_lat = 4;
      act0 = mem_act_cnt;
      do_inst(32'h6C, 2, ic, rc);
      check("s4_latency", 32'(rc - ic), 32'(5 + RESP_DLY));
      check("s4_mem_held", 32'(mem_act_cnt - act0), 32'h5);

      // reset in cycle 3 of a pending load, then a spurious mem_resp
      mem_lat = 20;
      bus.data_read = 1'b1; bus.data_addr = 32'h100; bus.data_mbe = 4'hF;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      bus.data_read = 1'b0;
      exp_data_q.delete();
      exp_inst_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_zero("rst_mid");
      @(negedge clk);
      force_resp = 1'b1;
      @(negedge clk);
      force_resp = 1'b0;
      check("spurious_data_resp", 32'(bus.data_resp), 32'h0);
      check("spurious_state", 32'(dbg_state), 32'(IDLE));
      @(posedge clk);
      #1;
      mem_lat = 0;

      // randomized traffic on both ports
      lat_rand = 1'b1;
      fork
         begin
            int ic_r, rc_r;
            for (int i = 0; i < 50; i++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               do_inst(32'h4000 + 4 * $urandom_range(0, 63), -1, ic_r, rc_r);
            end
         end
         begin
            int ic_d, rc_d, op;
            for (int i = 0; i < 50; i++) begin
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
               op = int'($urandom_range(0, 4));
               do_data((op < 2) || (op == 4), (op >= 2), 32'h1000 + 4 * $urandom_range(0, 15),
                       $urandom, 4'($urandom_range(0, 15)), ic_d, rc_d);
            end
         end
      join
      lat_rand = 1'b0;

      repeat (5) begin @(posedge clk); #1; end
      check("inst_q_drained", 32'(exp_inst_q.size()), 32'h0);
      check("data_q_drained", 32'(exp_data_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Single-port memory responder for the pipelined CPU's split instruction and data interfaces. It answers `inst_read` and `data_read`/`data_write` requests with one-cycle `*_resp` pulses, which satisfies the CPU's hold-until-resp stall rule. Internally it serializes both request streams onto one 32-bit downstream memory port with a registered request/response handshake. It sits between the CPU and the shared cache/memory.

## Interface
Parameters:
- none; all widths are fixed at 32-bit address, 32-bit data and a 4-bit byte mask.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `inst_read`  in  1  instruction fetch request; held until `inst_resp`.
- `inst_addr`  in  32  fetch address.
- `inst_rdata`  out  32  fetch data; valid while `inst_resp`.
- `inst_resp`  out  1  one-cycle completion pulse.
- `data_read`  in  1  load request; held until `data_resp`.
- `data_write`  in  1  store request; held until `data_resp`.
- `data_mbe`  in  4  store byte enables.
- `data_addr`  in  32  load/store address.
- `data_wdata`  in  32  store data.
- `data_rdata`  out  32  load data; valid while `data_resp`.
- `data_resp`  out  1  one-cycle completion pulse.
- `mem_read`, `mem_write`  out  1 each  downstream request; held until `mem_resp`.
- `mem_addr`  out  32  downstream address.
- `mem_wdata`  out  32  downstream store data.
- `mem_mbe`  out  4  downstream byte enables.
- `mem_rdata`  in  32  downstream read data.
- `mem_resp`  in  1  downstream completion pulse.

## Operation
- FSM states:
  - IDLE: no downstream transaction.
  - INST: serving the latched fetch.
  - DATA: serving the latched load/store.
- Grant in IDLE:
  - data has priority over inst.
  - Exception: if `last_grant` = DATA and `inst_read` is pending, grant INST.
  - `last_grant` is a 1-bit register updated on each grant.
- On grant, the selected port's addr/wdata/mbe/op are latched into request registers. Downstream outputs are driven only from these registers, never from the CPU ports.
- `data_read` and `data_write` asserted together is illegal; the arbiter treats it as a write.
- For inst grants, `mem_mbe` = 4'b1111 and `mem_wdata` = 0.
- INST/DATA: hold `mem_read`/`mem_write` until `mem_resp`. In the `mem_resp` cycle:
  - pulse the matching `*_resp`;
  - drive `*_rdata` = `mem_rdata`;
  - drop the downstream request;
  - return to IDLE.
- A CPU request that deasserts mid-transaction does not abort the transaction. The downstream access completes and the response still pulses.
- `inst_rdata`/`data_rdata` are 0 whenever the matching resp is low.

## Timing
- Reset: state = IDLE, `last_grant` = INST, and every output is 0.
- Reset mid-transaction: the downstream request drops the cycle after `rst`. Any `mem_resp` that arrives afterwards is ignored.
- Latency:
  - CPU request seen in IDLE in cycle N; `mem_*` is asserted in cycle N+1.
  - `*_resp` pulses in the same cycle as `mem_resp`.
  - The earliest next grant is evaluated in the cycle after that resp.
- Minimum round trip with a 1-cycle memory is 2 cycles, plus 1 IDLE cycle between transactions.
- A `mem_resp` received in IDLE is ignored.
- The arbiter never asserts `inst_resp` and `data_resp` in the same cycle.

## Configuration
- `ARB_RESP_REG_EN` defined:
  - `*_resp` and `*_rdata` are registered and appear one cycle after `mem_resp`.
  - The FSM passes through an extra RESP state before IDLE.
  - Round trip grows by one cycle; this cuts the memory-to-CPU combinational path.
- `ARB_RESP_REG_EN` undefined: pass-through behaviour as specified above.

## Structure
- Shared package `arb_types` holds:
  - the `arb_state_t` enum (IDLE, INST, DATA, RESP);
  - the `arb_grant_t` enum (GRANT_INST, GRANT_DATA).
- Single module; no sub-module. The request latch and FSM are small enough to stay inline.

## Test plan
- Reset, then `inst_read` = 1 with `inst_addr` = 0x60 and a 1-cycle memory returning 0x00000013 → `mem_read` rises in cycle 1 with `mem_addr` = 0x60. `inst_resp` = 1 and `inst_rdata` = 0x00000013 in the `mem_resp` cycle.
- Simultaneous `inst_read` (0x64) and `data_read` (0x100) → data is served first. Inst is served next, and both resps pulse in distinct cycles.
- Back-to-back: `data_write` to 0x200 with mbe 4'b0011 and wdata 0xDEADBEEF, followed immediately by another data request while `inst_read` is pending → the second grant goes to inst (fairness). The memory sees mbe 0011 and wdata 0xDEADBEEF.
- Memory latency of 5 cycles while the CPU drops `inst_read` in cycle 2 → `mem_read` is held all 5 cycles, `inst_resp` still pulses, and the FSM then returns to IDLE.
- `rst` asserted in cycle 3 of a pending load → all outputs are 0 next cycle. A later spurious `mem_resp` produces no `data_resp`.
- Repeat the first scenario with `ARB_RESP_REG_EN` defined → `inst_resp` arrives one cycle after `mem_resp`, still with data 0x00000013.
